// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared types, helpers and constants for the binary conv/pool layer
package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Default batch-norm thresholds of the second network layer, filters 0..3
    localparam int L2_THR_F0 = 41;
    localparam int L2_THR_F1 = 42;
    localparam int L2_THR_F2 = 35;
    localparam int L2_THR_F3 = 37;

endpackage

// File: rtl/bnn_xnor_popcount.sv
// rtl/bnn_xnor_popcount.sv - combinational XNOR-popcount over one 3x3xIN_CH window
module bnn_xnor_popcount
    import bnn_pkg::*;
#(
    parameter int IN_CH = 8,
    parameter int PCW   = clog2(9*IN_CH+1)
) (
    input  logic [9*IN_CH-1:0] act,
    input  logic [9*IN_CH-1:0] wgt,
    output logic [PCW-1:0]     pop
);

    logic [9*IN_CH-1:0] match;

    assign match = ~(act ^ wgt);

    // Count matching activation/weight bits
    always_comb begin
        pop = '0;
        for (int i = 0; i < 9*IN_CH; i++) begin
            pop = pop + PCW'(match[i]);
        end
    end

endmodule

// File: rtl/bnn_conv_pool_layer.sv
// rtl/bnn_conv_pool_layer.sv - 3x3 binary conv, per-filter threshold, 2x2 max-pool layer
module bnn_conv_pool_layer
    import bnn_pkg::*;
#(
    parameter int IN_DIM   = 14,
    parameter int IN_CH    = 8,
    parameter int NUM_FILT = 4,
    parameter int OUT_DIM  = IN_DIM/2,
    parameter int PCW      = clog2(9*IN_CH+1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [IN_DIM*IN_DIM*IN_CH-1:0]      pixels,
    input  logic [NUM_FILT*9*IN_CH-1:0]         weights,
    input  logic [NUM_FILT*PCW-1:0]             thresholds,
    input  logic [NUM_FILT-1:0]                 flip,
    output logic [NUM_FILT*OUT_DIM*OUT_DIM-1:0] layer_out,
    output logic                                busy,
    output logic                                done
);

    localparam int KW = 9*IN_CH;
    localparam int FW = (NUM_FILT > 1) ? clog2(NUM_FILT) : 1;
    localparam int RW = (OUT_DIM > 1) ? clog2(OUT_DIM) : 1;

    if ((IN_DIM % 2) != 0 || IN_DIM < 4) begin : g_bad_dim
        $error("bnn_conv_pool_layer: IN_DIM must be even and >= 4");
    end

    state_t          state;
    logic [FW-1:0]   cnt_f;
    logic [RW-1:0]   cnt_r;
    logic [RW-1:0]   cnt_c;
    logic            drain_cnt;
    logic            last_addr;

    logic [KW-1:0]   win [4];
    logic [KW-1:0]   wsel;
    logic [PCW-1:0]  pop_comb [4];

    logic            s1_valid;
    logic [PCW-1:0]  s1_pop [4];
    logic [FW-1:0]   s1_f;
    logic [RW-1:0]   s1_r;
    logic [RW-1:0]   s1_c;

    logic [PCW-1:0]  thr_sel;
    logic            flip_sel;
    logic            pool_bit;
    int              out_idx;

    assign last_addr = (cnt_f == FW'(NUM_FILT-1)) && (cnt_r == RW'(OUT_DIM-1)) &&
                       (cnt_c == RW'(OUT_DIM-1));
    assign wsel      = weights[int'(cnt_f)*KW +: KW];

    // Gather the four zero-padded 3x3 windows covering pooled cell (cnt_r, cnt_c)
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            win[p] = '0;
            for (int kr = 0; kr < 3; kr++) begin
                for (int kc = 0; kc < 3; kc++) begin
                    int rr;
                    int cc;
                    rr = 2*int'(cnt_r) + p/2 + kr - 1;
                    cc = 2*int'(cnt_c) + p%2 + kc - 1;
                    if (rr >= 0 && rr < IN_DIM && cc >= 0 && cc < IN_DIM) begin
                        win[p][(kr*3+kc)*IN_CH +: IN_CH] = pixels[(rr*IN_DIM+cc)*IN_CH +: IN_CH];
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < 4; p++) begin : g_pc
        bnn_xnor_popcount #(
            .IN_CH (IN_CH),
            .PCW   (PCW)
        ) u_popcount (
            .act (win[p]),
            .wgt (wsel),
            .pop (pop_comb[p])
        );
    end

    // Stage 1: register the four popcounts with their address
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_f     <= '0;
            s1_r     <= '0;
            s1_c     <= '0;
            for (int p = 0; p < 4; p++) s1_pop[p] <= '0;
        end else begin
            s1_valid <= (state == RUN);
            s1_f     <= cnt_f;
            s1_r     <= cnt_r;
            s1_c     <= cnt_c;
            s1_pop   <= pop_comb;
        end
    end

    assign thr_sel  = thresholds[int'(s1_f)*PCW +: PCW];
    assign flip_sel = flip[s1_f];
    assign out_idx  = int'(s1_f)*OUT_DIM*OUT_DIM + int'(s1_r)*OUT_DIM + int'(s1_c);

    // Threshold each pooled position and OR them together (max-pool of binary values)
    always_comb begin
        pool_bit = 1'b0;
        for (int p = 0; p < 4; p++) begin
            if (flip_sel) pool_bit = pool_bit | (s1_pop[p] <= thr_sel);
            else          pool_bit = pool_bit | (s1_pop[p] >= thr_sel);
        end
    end

    // Control FSM, address counters and stage-2 write into layer_out
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt_f     <= '0;
            cnt_r     <= '0;
            cnt_c     <= '0;
            drain_cnt <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            layer_out <= '0;
        end else begin
            if (s1_valid) layer_out[out_idx] <= pool_bit;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        cnt_f     <= '0;
                        cnt_r     <= '0;
                        cnt_c     <= '0;
                        layer_out <= '0;
                    end
                end
                RUN: begin
                    if (last_addr) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end else if (cnt_c != RW'(OUT_DIM-1)) begin
                        cnt_c <= cnt_c + RW'(1);
                    end else begin
                        cnt_c <= '0;
                        if (cnt_r != RW'(OUT_DIM-1)) begin
                            cnt_r <= cnt_r + RW'(1);
                        end else begin
                            cnt_r <= '0;
                            cnt_f <= cnt_f + FW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_conv_pool_layer.sv
// tb/tb_bnn_conv_pool_layer.sv - self-checking bench for bnn_conv_pool_layer
module tb_bnn_conv_pool_layer;
    import bnn_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         start_a = 1'b0;
    logic [1567:0] pix_a  = '0;
    logic [287:0] wts_a   = '0;
    logic [27:0]  thr_a   = '0;
    logic [3:0]   flip_a  = '0;
    logic [195:0] out_a;
    logic         busy_a, done_a;

    logic         start_b = 1'b0;
    logic [255:0] pix_b   = '0;
    logic [71:0]  wts_b   = '0;
    logic [11:0]  thr_b   = '0;
    logic [1:0]   flip_b  = '0;
    logic [31:0]  out_b;
    logic         busy_b, done_b;

    always #5 clk = ~clk;

    bnn_conv_pool_layer dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start_a),
        .pixels     (pix_a),
        .weights    (wts_a),
        .thresholds (thr_a),
        .flip       (flip_a),
        .layer_out  (out_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    bnn_conv_pool_layer #(.IN_DIM(8), .IN_CH(4), .NUM_FILT(2)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start_b),
        .pixels     (pix_b),
        .weights    (wts_b),
        .thresholds (thr_b),
        .flip       (flip_b),
        .layer_out  (out_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    typedef struct {
        int            sel;
        logic [1567:0] pix;
        logic [287:0]  wts;
        logic [27:0]   thr;
        logic [3:0]    fl;
        logic [195:0]  exp;
    } vec_t;

    typedef struct {
        logic [195:0] exp;
        int           cyc;
    } sb_t;

    vec_t vecs [8];
    sb_t  sb_q [$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [195:0] act, input logic [195:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    function automatic logic [195:0] out_of(input int sel);
        return (sel == 0) ? out_a : {164'b0, out_b};
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 0) ? done_a : done_b;
    endfunction

    function automatic logic [195:0] model(input int d, input int ch, input int nf, input int pw,
                                           input logic [1567:0] px, input logic [287:0] w,
                                           input logic [27:0] th, input logic [3:0] fl);
        logic [195:0] res;
        int od;
        res = '0;
        od  = d/2;
        for (int f = 0; f < nf; f++) begin
            int thr;
            thr = int'((th >> (f*pw)) & ((28'd1 << pw) - 28'd1));
            for (int r = 0; r < od; r++) begin
                for (int c = 0; c < od; c++) begin
                    logic b;
                    b = 1'b0;
                    for (int q = 0; q < 4; q++) begin
                        int pop;
                        pop = 0;
                        for (int kr = 0; kr < 3; kr++)
                            for (int kc = 0; kc < 3; kc++)
                                for (int k = 0; k < ch; k++) begin
                                    int rr, cc;
                                    logic pb, wb;
                                    rr = 2*r + q/2 + kr - 1;
                                    cc = 2*c + q%2 + kc - 1;
                                    pb = (rr >= 0 && rr < d && cc >= 0 && cc < d) ? px[(rr*d+cc)*ch+k] : 1'b0;
                                    wb = w[f*9*ch + (kr*3+kc)*ch + k];
                                    if (pb == wb) pop++;
                                end
                        if (fl[f]) b = b | (pop <= thr);
                        else       b = b | (pop >= thr);
                    end
                    res[f*od*od + r*od + c] = b;
                end
            end
        end
        return res;
    endfunction

    task automatic load(input int i);
        @(negedge clk);
        if (vecs[i].sel == 0) begin
            pix_a  = vecs[i].pix;
            wts_a  = vecs[i].wts;
            thr_a  = vecs[i].thr;
            flip_a = vecs[i].fl;
        end else begin
            pix_b  = vecs[i].pix[255:0];
            wts_b  = vecs[i].wts[71:0];
            thr_b  = vecs[i].thr[11:0];
            flip_b = vecs[i].fl[1:0];
        end
    endtask

    task automatic run_pass(input int sel, input bit hold);
        int  n;
        int  busyc;
        sb_t e;
        @(negedge clk);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        chk("post_start_busy", 196'(busy_of(sel)), 196'd1);
        chk("post_start_done", 196'(done_of(sel)), 196'd0);
        chk("post_start_clear", out_of(sel), 196'd0);
        n     = 0;
        busyc = busy_of(sel) ? 1 : 0;
        while (!done_of(sel) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (busy_of(sel)) busyc++;
            if (hold && n == 50) begin
                if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
            end
            if (hold && n == 60) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
        end
        e = sb_q.pop_front();
        chk("done_cycles", 196'(n), 196'(e.cyc));
        chk("busy_cycles", 196'(busyc), 196'(e.cyc));
        chk("layer_out", out_of(sel), e.exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] thr_l2;
        logic [195:0] mask02;
        int n;

        thr_l2 = {7'(L2_THR_F3), 7'(L2_THR_F2), 7'(L2_THR_F1), 7'(L2_THR_F0)};
        for (int k = 0; k < 196; k++) mask02[k] = ((k/49) % 2) == 0;

        vecs[0] = '{0, '0, '0, {4{7'd41}}, 4'b0000, {196{1'b1}}};
        vecs[1] = '{0, '0, {288{1'b1}}, {4{7'd1}}, 4'b0000, 196'd0};
        vecs[2] = '{0, '0, {288{1'b1}}, {7'd1, 7'd0, 7'd1, 7'd0}, 4'b0101, mask02};
        vecs[3] = '{0, {1568{1'b1}}, {288{1'b1}}, {4{7'd72}}, 4'b0000, '0};
        vecs[4] = '{0, {1568{1'b1}}, {288{1'b1}}, {4{7'd71}}, 4'b1111, '0};
        vecs[5] = '{0, '0, '0, thr_l2, 4'b1010, '0};
        vecs[6] = '{1, '0, '0, '0, '0, '0};
        vecs[7] = '{1, '0, '0, '0, '0, '0};
        for (int k = 0; k < 1568; k++) vecs[5].pix[k] = 1'($urandom_range(0, 1));
        for (int k = 0; k < 288; k++)  vecs[5].wts[k] = 1'($urandom_range(0, 1));
        for (int v = 6; v < 8; v++) begin
            for (int k = 0; k < 256; k++) vecs[v].pix[k] = 1'($urandom_range(0, 1));
            for (int k = 0; k < 72; k++)  vecs[v].wts[k] = 1'($urandom_range(0, 1));
            vecs[v].thr = {16'd0, 6'($urandom_range(14, 22)), 6'($urandom_range(14, 22))};
            vecs[v].fl  = {2'b00, 2'($urandom_range(0, 3))};
        end
        for (int v = 3; v < 8; v++) begin
            if (vecs[v].sel == 0)
                vecs[v].exp = model(14, 8, 4, 7, vecs[v].pix, vecs[v].wts, vecs[v].thr, vecs[v].fl);
            else
                vecs[v].exp = model(8, 4, 2, 6, vecs[v].pix, vecs[v].wts, vecs[v].thr, vecs[v].fl);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_a", out_a, 196'd0);
        chk("reset_busy_a", 196'(busy_a), 196'd0);
        chk("reset_done_a", 196'(done_a), 196'd0);
        chk("reset_out_b", {164'b0, out_b}, 196'd0);
        chk("reset_done_b", 196'(done_b), 196'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            load(i);
            sb_q.push_back('{vecs[i].exp, (vecs[i].sel == 0) ? 198 : 34});
            run_pass(vecs[i].sel, i == 0);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("done_level_held", 196'(done_b), 196'd1);

        load(0);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pre_reset_nonzero", 196'(out_a != 196'd0), 196'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_out_a", out_a, 196'd0);
        chk("abort_busy_a", 196'(busy_a), 196'd0);
        chk("abort_done_a", 196'(done_a), 196'd0);
        chk("abort_done_b", 196'(done_b), 196'd0);
        rst = 1'b0;
        sb_q.push_back('{vecs[0].exp, 198});
        run_pass(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
